// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow flop
// produce A - B LSB first over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Returns {borrow_out, difference_bit} for x - y - br.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
    logic d;
    logic br_out;
    d      = x ^ y ^ br;
    br_out = (~x & y) | (~(x ^ y) & br);
    return {br_out, d};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             accept_s;
  logic             last_s;
  logic [1:0]       cell_s;
  logic [WIDTH:0]   res_cat_s;
  logic [WIDTH-1:0] res_next_s;

  assign accept_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_s     = (cnt_q == CW'(WIDTH - 1));
  assign cell_s     = full_sub(a_sr_q[0], b_sr_q[0], br_q);
  assign res_cat_s  = {cell_s[0], res_sr_q};
  assign res_next_s = res_cat_s[WIDTH:1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_SHIFT : S_IDLE;
      S_SHIFT: state_d = last_s ? S_DONE : S_SHIFT;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so busy/done come straight from flops.
  always_comb begin
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // Datapath: operand capture, serial shift and result load on the final bit.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    if (accept_s) begin
      a_sr_d   = a;
      b_sr_d   = b;
      res_sr_d = {WIDTH{1'b0}};
      br_d     = 1'b0;
      cnt_d    = {CW{1'b0}};
    end else if (state_q == S_SHIFT) begin
      a_sr_d   = a_sr_q >> 1'b1;
      b_sr_d   = b_sr_q >> 1'b1;
      res_sr_d = res_next_s;
      br_d     = cell_s[1];
      cnt_d    = cnt_q + CW'(1);
      if (last_s) begin
        diff_d   = res_next_s;
        borrow_d = cell_s[1];
        zero_d   = (res_next_s == {WIDTH{1'b0}});
      end else begin
        diff_d   = diff_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_sr_q <= {WIDTH{1'b0}};
      br_q     <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b, diff;
  logic       busy, done, borrow, zero;

  logic       start1;
  logic [0:0] a1, b1, diff1;
  logic       busy1, done1, borrow1, zero1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .zero(zero)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .zero(zero1)
  );

  // Drive start with operands for one edge; returns 1ns after the accepting edge.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic hold);
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Bounded wait for done; cyc is the cycle index after the accepting edge.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 1; busy_cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    #12;
    checks++;
    if ({busy, done, diff, borrow, zero} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b zero=%b, want all 0",
               busy, done, diff, borrow, zero);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc, bc;
    launch(8'h5A, 8'h23, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    wait_done(cyc, bc);
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", cyc); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    checks++;
    if ({busy, diff, borrow, zero} !== {1'b0, 8'h37, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got busy=%b diff=%h borrow=%b zero=%b want 0 37 0 0",
               busy, diff, borrow, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_borrow;
    int cyc, bc;
    launch(8'h10, 8'h20, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if ({diff, borrow, zero} !== {8'hF0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL borrow_10_20: got diff=%h borrow=%b zero=%b want F0 1 0", diff, borrow, zero);
    end
    launch(8'h00, 8'hFF, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if ({diff, borrow, zero} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL borrow_00_FF: got diff=%h borrow=%b zero=%b want 01 1 0", diff, borrow, zero);
    end
  endtask

  task automatic test_zero_hold;
    int cyc, bc;
    launch(8'h77, 8'h77, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if ({diff, borrow, zero} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_77_77: got diff=%h borrow=%b zero=%b want 00 0 1", diff, borrow, zero);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({diff, zero} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL zero_hold_idle: got diff=%h zero=%b want 00 1", diff, zero);
    end
    launch(8'h05, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({busy, diff, zero} !== {1'b1, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL zero_hold_busy: got busy=%b diff=%h zero=%b want 1 00 1", busy, diff, zero);
    end
    wait_done(cyc, bc);
    checks++;
    if ({done, diff, borrow, zero} !== {1'b1, 8'h04, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_next_op: got done=%b diff=%h borrow=%b zero=%b want 1 04 0 0",
               done, diff, borrow, zero);
    end
  endtask

  task automatic test_ignore_start;
    int done_cnt, done_at;
    logic [7:0] d_seen;
    done_cnt = 0; done_at = 0; d_seen = 8'h00;
    launch(8'h5A, 8'h23, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (c == 4) start = 1'b0;
      if (done === 1'b1) begin done_cnt++; done_at = c; d_seen = diff; end
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt !== 1 || done_at !== 9) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d dones at %0d want 1 at 9", done_cnt, done_at);
    end
    checks++;
    if (d_seen !== 8'h37) begin errors++; $display("FAIL ignore_result: got %h want 37", d_seen); end
  endtask

  task automatic test_back_to_back;
    int done_cnt;
    int at [2];
    logic [8:0] res [2];
    done_cnt = 0; at[0] = 0; at[1] = 0; res[0] = 9'h000; res[1] = 9'h000;
    launch(8'h80, 8'h01, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) begin a = 8'h01; b = 8'h02; end
      if (c == 10) start = 1'b0;
      if (done === 1'b1) begin
        if (done_cnt < 2) begin at[done_cnt] = c; res[done_cnt] = {diff, borrow}; end
        done_cnt++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", done_cnt); end
    checks++;
    if (at[0] !== 9 || at[1] !== 18) begin
      errors++;
      $display("FAIL b2b_timing: got %0d,%0d want 9,18", at[0], at[1]);
    end
    checks++;
    if (res[0] !== {8'h7F, 1'b0}) begin errors++; $display("FAIL b2b_first: got %h want 0fe", res[0]); end
    checks++;
    if (res[1] !== {8'hFF, 1'b1}) begin errors++; $display("FAIL b2b_second: got %h want 1ff", res[1]); end
  endtask

  task automatic test_abort;
    int cyc, bc, seen;
    launch(8'h33, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow, zero} !== 12'h000) begin
      errors++;
      $display("FAIL abort_async: got busy=%b done=%b diff=%h borrow=%b zero=%b want all 0",
               busy, done, diff, borrow, zero);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones want 0", seen); end
    rst_n = 1'b1;
    launch(8'h0A, 8'h03, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if (cyc !== 9 || diff !== 8'h07 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: got cyc=%0d diff=%h borrow=%b want 9 07 0", cyc, diff, borrow);
    end
  endtask

  task automatic test_width1;
    @(posedge clk); #1;
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_shift: got busy=%b done=%b want 1 0", busy1, done1);
    end
    @(posedge clk); #1;
    checks++;
    if ({done1, busy1, diff1, borrow1, zero1} !== 5'b10110) begin
      errors++;
      $display("FAIL w1_result: got done=%b busy=%b diff=%b borrow=%b zero=%b want 1 0 1 1 0",
               done1, busy1, diff1, borrow1, zero1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero_hold();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
